// File: rtl/sha_digest_unload_if.sv
// Digest-unload bus: capture strobe and hash word in from compression control,
// one-word-at-a-time valid/ready stream and status flags out to the host.
interface sha_digest_unload_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int IDX_W     = 3
);
    logic                          DIGEST_VALID;
    logic [WORD_W*NUM_WORDS-1:0]   DIGEST_IN;
    logic [WORD_W-1:0]             OUT_DATA;
    logic                          OUT_VALID;
    logic                          OUT_READY;
    logic                          OUT_LAST;
    logic [IDX_W-1:0]              OUT_IDX;
    logic                          BUSY;
    logic                          DONE_PULSE;
    logic                          OVERRUN;

    modport master (
        input  DIGEST_VALID, DIGEST_IN, OUT_READY,
        output OUT_DATA, OUT_VALID, OUT_LAST, OUT_IDX, BUSY, DONE_PULSE, OVERRUN
    );

    modport slave (
        output DIGEST_VALID, DIGEST_IN, OUT_READY,
        input  OUT_DATA, OUT_VALID, OUT_LAST, OUT_IDX, BUSY, DONE_PULSE, OVERRUN
    );
endinterface

// File: rtl/sha_digest_unload.sv
// Captures the final SHA-256 state on DIGEST_VALID and streams it out H0..H7,
// one word per accepted handshake, flagging digests that arrive while busy.
module sha_digest_unload #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    sha_digest_unload_if.master  bus
);
    localparam int               DIG_W    = WORD_W * NUM_WORDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t             r_state;
    logic [DIG_W-1:0]   r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;
    logic               w_xfer;

    assign w_xfer = r_valid && bus.OUT_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.DIGEST_VALID) begin
                        r_state <= STREAM;
                        r_shift <= bus.DIGEST_IN;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (LAST_IDX == '0);
                        r_busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (bus.DIGEST_VALID)
                        r_overrun <= 1'b1;
                    if (w_xfer) begin
                        r_shift <= r_shift << WORD_W;
                        if (r_idx == LAST_IDX) begin
                            // Index returns to 0 instead of stepping past the last word.
                            r_state <= DONE;
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_last <= ((r_idx + 1'b1) == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    if (bus.DIGEST_VALID)
                        r_overrun <= 1'b1;
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.OUT_DATA   = r_shift[DIG_W-1 -: WORD_W];
    assign bus.OUT_VALID  = r_valid;
    assign bus.OUT_LAST   = r_last;
    assign bus.OUT_IDX    = r_idx;
    assign bus.BUSY       = r_busy;
    assign bus.DONE_PULSE = r_done;
    assign bus.OVERRUN    = r_overrun;
endmodule

// File: tb/tb_sha_digest_unload.sv
// Directed bench for sha_digest_unload: streaming, backpressure, overrun,
// mid-stream reset, back-to-back digests and reset/capture collision.
module tb_sha_digest_unload;
    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ONES = {8{32'h11111111}};
    localparam logic [255:0] A5   = {8{32'hA5A5A5A5}};

    logic CLK = 1'b0;
    logic RESET;
    int   errors = 0;
    int   checks = 0;

    sha_digest_unload_if #(.WORD_W(32), .NUM_WORDS(8), .IDX_W(3)) bus ();

    sha_digest_unload #(.WORD_W(32), .NUM_WORDS(8), .IDX_W(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [255:0] d, input int i);
        return d[255 - 32*i -: 32];
    endfunction

    task automatic capture(input logic [255:0] d);
        bus.DIGEST_VALID = 1'b1;
        bus.DIGEST_IN    = d;
        tick();
        bus.DIGEST_VALID = 1'b0;
        bus.DIGEST_IN    = '0;
    endtask

    // Expects a stream at index 0 with OUT_READY high; ends in the DONE cycle.
    task automatic drain(input string tag, input logic [255:0] d);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_valid"}, 64'(bus.OUT_VALID), 64'd1);
            chk({tag, "_data"},  64'(bus.OUT_DATA),  64'(word_of(d, i)));
            chk({tag, "_idx"},   64'(bus.OUT_IDX),   64'(i));
            chk({tag, "_last"},  64'(bus.OUT_LAST),  64'(i == 7));
            tick();
        end
        chk({tag, "_done_valid"}, 64'(bus.OUT_VALID),  64'd0);
        chk({tag, "_done_pulse"}, 64'(bus.DONE_PULSE), 64'd1);
        chk({tag, "_done_busy"},  64'(bus.BUSY),       64'd1);
    endtask

    initial begin
        int k;
        logic [19:0] pat;
        RESET            = 1'b1;
        bus.DIGEST_VALID = 1'b0;
        bus.DIGEST_IN    = '0;
        bus.OUT_READY    = 1'b0;
        tick();
        tick();
        RESET = 1'b0;

        chk("rst_valid",   64'(bus.OUT_VALID),  64'd0);
        chk("rst_data",    64'(bus.OUT_DATA),   64'd0);
        chk("rst_idx",     64'(bus.OUT_IDX),    64'd0);
        chk("rst_last",    64'(bus.OUT_LAST),   64'd0);
        chk("rst_busy",    64'(bus.BUSY),       64'd0);
        chk("rst_done",    64'(bus.DONE_PULSE), 64'd0);
        chk("rst_overrun", 64'(bus.OVERRUN),    64'd0);

        // 1: full-throughput "abc" digest
        bus.OUT_READY = 1'b1;
        capture(ABC);
        chk("t1_busy", 64'(bus.BUSY), 64'd1);
        drain("t1", ABC);
        tick();
        chk("t1_idle_busy", 64'(bus.BUSY),       64'd0);
        chk("t1_idle_done", 64'(bus.DONE_PULSE), 64'd0);
        chk("t1_idle_data", 64'(bus.OUT_DATA),   64'd0);
        chk("t1_overrun",   64'(bus.OVERRUN),    64'd0);

        // 2: backpressure with a fixed irregular ready pattern
        bus.OUT_READY = 1'b0;
        capture(ABC);
        pat = 20'b1001_0110_1100_1011_0011;
        k = 0;
        for (int c = 0; c < 60; c++) begin
            bus.OUT_READY = pat[19 - (c % 20)];
            chk("t2_valid", 64'(bus.OUT_VALID), 64'd1);
            chk("t2_data",  64'(bus.OUT_DATA),  64'(word_of(ABC, k)));
            chk("t2_idx",   64'(bus.OUT_IDX),   64'(k));
            chk("t2_last",  64'(bus.OUT_LAST),  64'(k == 7));
            tick();
            if (bus.OUT_READY) k++;
            if (k == 8) break;
        end
        chk("t2_count", 64'(k), 64'd8);
        chk("t2_done",  64'(bus.DONE_PULSE), 64'd1);
        bus.OUT_READY = 1'b1;
        tick();
        chk("t2_idle_busy", 64'(bus.BUSY), 64'd0);

        // 3: overrun at word 3
        capture(ABC);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                bus.DIGEST_VALID = 1'b1;
                bus.DIGEST_IN    = ONES;
            end
            chk("t3_data", 64'(bus.OUT_DATA), 64'(word_of(ABC, i)));
            chk("t3_idx",  64'(bus.OUT_IDX),  64'(i));
            tick();
            bus.DIGEST_VALID = 1'b0;
            bus.DIGEST_IN    = '0;
        end
        chk("t3_overrun", 64'(bus.OVERRUN),    64'd1);
        chk("t3_done",    64'(bus.DONE_PULSE), 64'd1);
        tick();
        tick();
        chk("t3_no_restream", 64'(bus.OUT_VALID), 64'd0);
        chk("t3_busy",        64'(bus.BUSY),      64'd0);
        chk("t3_sticky",      64'(bus.OVERRUN),   64'd1);

        // 4: reset after word 4 transfers, then a fresh digest
        capture(ABC);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_pre_idx", 64'(bus.OUT_IDX), 64'd5);
        bus.OUT_READY = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("t4_valid",   64'(bus.OUT_VALID), 64'd0);
        chk("t4_overrun", 64'(bus.OVERRUN),   64'd0);
        chk("t4_busy",    64'(bus.BUSY),      64'd0);
        chk("t4_idx",     64'(bus.OUT_IDX),   64'd0);
        bus.OUT_READY = 1'b1;
        capture(A5);
        drain("t4", A5);
        tick();

        // 5: digest in DONE is dropped, digest on first IDLE cycle is captured
        capture(ABC);
        for (int i = 0; i < 8; i++) tick();
        chk("t5_in_done", 64'(bus.DONE_PULSE), 64'd1);
        capture(ONES);
        chk("t5_overrun",  64'(bus.OVERRUN),   64'd1);
        chk("t5_idle",     64'(bus.OUT_VALID), 64'd0);
        capture(A5);
        chk("t5_overrun2", 64'(bus.OVERRUN),   64'd1);
        drain("t5", A5);
        tick();

        // 6: reset and capture in the same cycle
        RESET            = 1'b1;
        bus.DIGEST_VALID = 1'b1;
        bus.DIGEST_IN    = ABC;
        tick();
        RESET            = 1'b0;
        bus.DIGEST_VALID = 1'b0;
        bus.DIGEST_IN    = '0;
        chk("t6_busy",    64'(bus.BUSY),      64'd0);
        chk("t6_valid",   64'(bus.OUT_VALID), 64'd0);
        chk("t6_data",    64'(bus.OUT_DATA),  64'd0);
        chk("t6_overrun", 64'(bus.OVERRUN),   64'd0);
        tick();
        chk("t6_still_idle", 64'(bus.OUT_VALID), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
